// File: rtl/sense_input_conditioner_if.sv
// Signal bundle between the raw-input conditioner and its consumer.
// The master side drives the qualifiers, the threshold and the raw input. The slave side is the conditioner itself.
interface sense_input_conditioner_if #(
    parameter int FILTER_WIDTH = 4
);
    logic                    clk_en;
    logic                    filter_en_i;
    logic [FILTER_WIDTH-1:0] threshold_i;
    logic                    raw_i;
    logic                    filtered_o;
    logic                    pending_o;
    logic                    glitch_o;
    logic [FILTER_WIDTH-1:0] persist_count_o;

    modport master (
        output clk_en, filter_en_i, threshold_i, raw_i,
        input  filtered_o, pending_o, glitch_o, persist_count_o
    );

    modport slave (
        input  clk_en, filter_en_i, threshold_i, raw_i,
        output filtered_o, pending_o, glitch_o, persist_count_o
    );
endinterface

// File: rtl/sense_input_conditioner.sv
// Synchroniser plus per-edge persistence filter for one asynchronous input.
// A new level is committed only after it has held for max(threshold,1) qualified samples. Abandoned transitions pulse glitch_o.
module sense_input_conditioner #(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      async_rst_n,
    sense_input_conditioner_if.slave  bus
);

    // The state encoding puts filtered_o in bit 1 and pending_o in bit 0.
    // Both outputs then come straight from flops.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        PEND_HIGH   = 2'b01,
        STABLE_HIGH = 2'b10,
        PEND_LOW    = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    s;
    state_t                  state_q, state_d;
    logic [FILTER_WIDTH-1:0] count_q, count_d;
    logic                    glitch_q, glitch_d;
    logic [FILTER_WIDTH-1:0] thr_eff;
    logic [FILTER_WIDTH:0]   count_inc;
    logic                    reached;

    assign s         = sync_q[SYNC_STAGES-1];
    assign thr_eff   = (bus.threshold_i == '0) ? FILTER_WIDTH'(1) : bus.threshold_i;
    assign count_inc = {1'b0, count_q} + {{FILTER_WIDTH{1'b0}}, 1'b1};
    // The stable states hold count 0, so "reached" there means T == 1 and the commit is immediate.
    assign reached   = (count_inc >= {1'b0, thr_eff});

    // NOTE: clocked state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            sync_q <= '0;
        end else if (bus.clk_en) begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.raw_i};
        end
    end

    // NOTE: next-state values get defaults before any branch, so no path leaves them unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        glitch_d = 1'b0;

        if (!bus.filter_en_i) begin
            state_d = STABLE_LOW;
            count_d = '0;
        end else begin
            unique case (state_q)
                STABLE_LOW: begin
                    count_d = '0;
                    if (s) begin
                        if (reached) begin
                            state_d = STABLE_HIGH;
                        end else begin
                            state_d = PEND_HIGH;
                            count_d = count_inc[FILTER_WIDTH-1:0];
                        end
                    end
                end
                STABLE_HIGH: begin
                    count_d = '0;
                    if (!s) begin
                        if (reached) begin
                            state_d = STABLE_LOW;
                        end else begin
                            state_d = PEND_LOW;
                            count_d = count_inc[FILTER_WIDTH-1:0];
                        end
                    end
                end
                PEND_HIGH: begin
                    if (!s) begin
                        state_d  = STABLE_LOW;
                        count_d  = '0;
                        glitch_d = 1'b1;
                    end else if (reached) begin
                        state_d = STABLE_HIGH;
                        count_d = '0;
                    end else begin
                        count_d = count_inc[FILTER_WIDTH-1:0];
                    end
                end
                PEND_LOW: begin
                    if (s) begin
                        state_d  = STABLE_HIGH;
                        count_d  = '0;
                        glitch_d = 1'b1;
                    end else if (reached) begin
                        state_d = STABLE_LOW;
                        count_d = '0;
                    end else begin
                        count_d = count_inc[FILTER_WIDTH-1:0];
                    end
                end
                default: begin
                    state_d = STABLE_LOW;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q  <= STABLE_LOW;
            count_q  <= '0;
            glitch_q <= 1'b0;
        end else if (bus.clk_en) begin
            state_q  <= state_d;
            count_q  <= count_d;
            glitch_q <= glitch_d;
        end
    end

    assign bus.filtered_o      = state_q[1];
    assign bus.pending_o       = state_q[0];
    assign bus.glitch_o        = glitch_q;
    assign bus.persist_count_o = count_q;

endmodule

// File: tb/tb_sense_input_conditioner.sv
// Bench for sense_input_conditioner: directed scenarios plus random stimulus.
// All of it is compared every cycle against a level/counter reference model.
module tb_sense_input_conditioner;

    localparam int S = 2;
    localparam int W = 4;

    logic clk = 1'b0;
    logic async_rst_n;
    always #5 clk = ~clk;

    sense_input_conditioner_if #(.FILTER_WIDTH(W)) bus ();

    sense_input_conditioner #(
        .SYNC_STAGES (S),
        .FILTER_WIDTH(W)
    ) dut (
        .clk        (clk),
        .async_rst_n(async_rst_n),
        .bus        (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // The model tracks the committed level and the length of the current run that disagrees with it.
    // The queue holds the raw samples still travelling through the synchroniser.
    bit q[$];
    int m_lvl, m_cnt, m_glt;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < S; i++) q.push_front(1'b0);
        m_lvl = 0; m_cnt = 0; m_glt = 0;
    endtask

    task automatic model_edge();
        int t;
        int s;
        t = int'(bus.threshold_i);
        if (t == 0) t = 1;
        s = int'(q[$]);
        q.pop_back();
        q.push_front(bus.raw_i);
        if (!bus.filter_en_i) begin
            m_lvl = 0; m_cnt = 0; m_glt = 0;
        end else if (s == m_lvl) begin
            m_glt = (m_cnt != 0) ? 1 : 0;
            m_cnt = 0;
        end else if (m_cnt + 1 >= t) begin
            m_lvl = 1 - m_lvl; m_cnt = 0; m_glt = 0;
        end else begin
            m_cnt++; m_glt = 0;
        end
    endtask

    task automatic compare();
        check("filtered", 32'(bus.filtered_o), 32'(m_lvl));
        check("pending",  32'(bus.pending_o),  (m_cnt != 0) ? 32'd1 : 32'd0);
        check("glitch",   32'(bus.glitch_o),   32'(m_glt));
        check("count",    32'(bus.persist_count_o), 32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        if (bus.clk_en) model_edge();
        #1;
        compare();
    endtask

    task automatic edges_until(input logic lvl, input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.filtered_o !== lvl && n < max);
    endtask

    int n, pulses;

    initial begin
        bus.clk_en      = 1'b1;
        bus.filter_en_i = 1'b1;
        bus.threshold_i = W'(4);
        bus.raw_i       = 1'b0;
        async_rst_n     = 1'b0;
        model_reset();
        #3;
        compare();
        @(negedge clk);
        async_rst_n = 1'b1;

        // A clean step in each direction.
        bus.raw_i = 1'b1;
        edges_until(1'b1, 20, n);
        check("lat_rise_t4", n, 6);
        bus.raw_i = 1'b0;
        edges_until(1'b0, 20, n);
        check("lat_fall_t4", n, 6);

        // A three-sample pulse is rejected and produces exactly one glitch cycle.
        bus.raw_i = 1'b1;
        repeat (3) tick();
        bus.raw_i = 1'b0;
        pulses = 0;
        repeat (8) begin
            tick();
            if (bus.glitch_o) pulses++;
        end
        check("glitch_pulses", pulses, 1);
        check("glitch_no_commit", 32'(bus.filtered_o), 0);

        // A glitch pulse that is already high holds while clk_en is low.
        bus.raw_i = 1'b1;
        repeat (3) tick();
        bus.raw_i = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.glitch_o && n < 10);
        check("glitch_seen", 32'(bus.glitch_o), 1);
        bus.clk_en = 1'b0;
        repeat (3) tick();
        check("glitch_hold", 32'(bus.glitch_o), 1);
        bus.clk_en = 1'b1;
        tick();
        check("glitch_clear", 32'(bus.glitch_o), 0);

        // A threshold of 0 behaves as 1.
        bus.threshold_i = '0;
        bus.raw_i = 1'b1;
        edges_until(1'b1, 20, n);
        check("lat_rise_t0", n, 3);
        bus.raw_i = 1'b0;
        edges_until(1'b0, 20, n);
        check("lat_fall_t0", n, 3);

        // Lowering the threshold in the middle of a pend.
        bus.threshold_i = W'(8);
        bus.raw_i = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.persist_count_o != W'(5) && n < 20);
        check("live_cnt5", 32'(bus.persist_count_o), 5);
        bus.threshold_i = W'(2);
        tick();
        check("live_commit", 32'(bus.filtered_o), 1);
        check("live_cnt0", 32'(bus.persist_count_o), 0);
        bus.threshold_i = W'(4);
        bus.raw_i = 1'b0;
        edges_until(1'b0, 20, n);

        // With clk_en alternating, only every other clock is qualified.
        bus.raw_i = 1'b1;
        n = 0;
        do begin
            bus.clk_en = (n % 2 == 1);
            tick();
            n++;
        end while (bus.filtered_o !== 1'b1 && n < 40);
        check("lat_clk_en", n, 12);
        bus.clk_en = 1'b1;

        // Dropping filter_en_i forces the output low without a glitch pulse.
        bus.filter_en_i = 1'b0;
        tick();
        check("fen_low", 32'(bus.filtered_o), 0);
        check("fen_no_glitch", 32'(bus.glitch_o), 0);
        repeat (2) tick();
        bus.filter_en_i = 1'b1;
        edges_until(1'b1, 20, n);
        check("fen_reenable", n, 4);

        // Asserting reset during a pend.
        bus.raw_i = 1'b0;
        edges_until(1'b0, 20, n);
        bus.raw_i = 1'b1;
        repeat (3) tick();
        check("pend_before_rst", 32'(bus.pending_o), 1);
        #2;
        async_rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        @(negedge clk);
        async_rst_n = 1'b1;
        edges_until(1'b1, 20, n);
        check("lat_after_rst", n, 6);

        // Random stimulus.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) bus.raw_i = ~bus.raw_i;
            if ($urandom_range(0, 19) == 0) bus.threshold_i = W'($urandom_range(0, 5));
            bus.clk_en      = ($urandom_range(0, 4) != 0);
            bus.filter_en_i = ($urandom_range(0, 49) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
